fetch_queue: RTL and testbench

- Decode-side receiver for the 2-wide fetch stage's fd_reg pair (inst_a/inst_b, pc_a/pc_b).
- Buffers fetched instructions in a circular queue, drops zero (end-of-program) words, and presents up to two instructions per cycle in program order to decode.
- Generates back-pressure (fq_ready) for the PC source and supports flush on redirect.

---
 rtl/fetch_queue_if.sv | 52 +++++
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_pkg / fetch_queue_if
//  Description : Shared fetch-pair typedef and the bus interface between the
//                2-wide fetch stage / decode and the fetch queue.
//                master : fetch + decode side (drives fd_reg, fd_valid, flush,
//                         dec_take; observes queue outputs)
//                slave  : fetch queue (consumes the above, drives fq_ready,
//                         out_* slots, count, overflow)
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] inst_a;
        logic [31:0] inst_b;
        logic [31:0] pc_a;
        logic [31:0] pc_b;
    } fetchStruct;
endpackage

interface fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_queue_pkg::fetchStruct fd_reg;
    logic                        fd_valid;
    logic                        flush;
    logic [1:0]                  dec_take;
    logic                        fq_ready;
    logic                        out_valid_a;
    logic [31:0]                 out_inst_a;
    logic [31:0]                 out_pc_a;
    logic                        out_valid_b;
    logic [31:0]                 out_inst_b;
    logic [31:0]                 out_pc_b;
    logic [CW-1:0]               count;
    logic                        overflow;

    modport master (
        output fd_reg, fd_valid, flush, dec_take,
        input  fq_ready, out_valid_a, out_inst_a, out_pc_a,
               out_valid_b, out_inst_b, out_pc_b, count, overflow
    );

    modport slave (
        input  fd_reg, fd_valid, flush, dec_take,
        output fq_ready, out_valid_a, out_inst_a, out_pc_a,
               out_valid_b, out_inst_b, out_pc_b, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Decode-side circular queue for the 2-wide fetch pair.
//                Drops zero (end-of-program) words, compacts live lanes in
//                program order, presents up to two show-ahead instructions
//                per cycle, raises fq_ready back-pressure and handles flush.
//  Ports       : clk   - clock, rising edge
//                reset - synchronous, active-high
//                bus   - fetch_queue_if.slave (fd_reg, fd_valid, flush,
//                        dec_take in; fq_ready, out_* slots, count,
//                        overflow out)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fetch_queue_if.slave       bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_next_q, drop_next_d;
    logic          overflow_q, overflow_d;

    logic          w_live_a, w_live_b;
    logic [1:0]    w_n_enq;
    logic [CW-1:0] w_take;
    logic [CW-1:0] w_n_deq;
    logic [CW:0]   w_sum;
    logic          w_cand;
    logic          w_fits;
    logic          w_wr0_en, w_wr1_en;
    logic [31:0]   w_wr0_inst, w_wr0_pc;
    logic [AW-1:0] w_head_p1;

    always_comb begin
        w_live_a   = (bus.fd_reg.inst_a != 32'd0);
        w_live_b   = (bus.fd_reg.inst_b != 32'd0);
        w_n_enq    = {1'b0, w_live_a} + {1'b0, w_live_b};
        // Clamp the decode request to what is actually held.
        w_take     = CW'(bus.dec_take);
        w_n_deq    = (w_take > count_q) ? count_q : w_take;
        w_sum      = {1'b0, count_q} - {1'b0, w_n_deq} + (CW+1)'(w_n_enq);
        // The pair right after a flush is stale in-flight fetch; ignore it.
        w_cand     = bus.fd_valid && !drop_next_q;
        w_fits     = (w_sum <= (CW+1)'(DEPTH));
        // Lane a wins the first slot when live, otherwise lane b slides down.
        w_wr0_inst = w_live_a ? bus.fd_reg.inst_a : bus.fd_reg.inst_b;
        w_wr0_pc   = w_live_a ? bus.fd_reg.pc_a   : bus.fd_reg.pc_b;
        w_wr0_en   = !reset && !bus.flush && w_cand && w_fits && (w_n_enq != 2'd0);
        w_wr1_en   = w_wr0_en && (w_n_enq == 2'd2);

        head_d      = head_q + AW'(w_n_deq);
        tail_d      = tail_q;
        count_d     = count_q - w_n_deq;
        drop_next_d = 1'b0;
        overflow_d  = overflow_q;

        if (w_cand) begin
            if (w_fits) begin
                tail_d  = tail_q + AW'(w_n_enq);
                count_d = CW'(w_sum);
            end else begin
                // Whole pair is lost; no partial write.
                overflow_d = 1'b1;
            end
        end

        if (bus.flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            drop_next_d = 1'b1;
            overflow_d  = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            drop_next_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            drop_next_q <= drop_next_d;
            overflow_q  <= overflow_d;
        end
    end

    // Payload storage needs no reset: outputs are masked by the valids.
    always_ff @(posedge clk) begin
        if (w_wr0_en) begin
            inst_mem_q[tail_q] <= w_wr0_inst;
            pc_mem_q[tail_q]   <= w_wr0_pc;
        end
        if (w_wr1_en) begin
            inst_mem_q[tail_q + AW'(1)] <= bus.fd_reg.inst_b;
            pc_mem_q[tail_q + AW'(1)]   <= bus.fd_reg.pc_b;
        end
    end

    always_comb begin
        w_head_p1       = head_q + AW'(1);
        bus.out_valid_a = (count_q >= CW'(1));
        bus.out_valid_b = (count_q >= CW'(2));
        bus.out_inst_a  = bus.out_valid_a ? inst_mem_q[head_q]    : 32'd0;
        bus.out_pc_a    = bus.out_valid_a ? pc_mem_q[head_q]      : 32'd0;
        bus.out_inst_b  = bus.out_valid_b ? inst_mem_q[w_head_p1] : 32'd0;
        bus.out_pc_b    = bus.out_valid_b ? pc_mem_q[w_head_p1]   : 32'd0;
        // Four free slots absorb the pair already in flight after a stall.
        bus.fq_ready    = ((CW'(DEPTH) - count_q) >= CW'(4));
        bus.count       = count_q;
        bus.overflow    = overflow_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue (DEPTH=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    fetch_queue_if #(.DEPTH(8)) bus ();

    fetch_queue #(.DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic fv, input logic [31:0] ia, input logic [31:0] pa,
                         input logic [31:0] ib, input logic [31:0] pb,
                         input logic [1:0] take, input logic fl);
        bus.fd_valid      = fv;
        bus.fd_reg.inst_a = ia;
        bus.fd_reg.pc_a   = pa;
        bus.fd_reg.inst_b = ib;
        bus.fd_reg.pc_b   = pb;
        bus.dec_take      = take;
        bus.flush         = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Enqueue full pair k: pcs 8k, 8k+4, inst = 0x1000 + pc.
    task automatic push_pair(input int k, input logic [1:0] take);
        drive(1'b1, 32'h1000 + 32'(8*k), 32'(8*k), 32'h1004 + 32'(8*k), 32'(8*k+4), take, 1'b0);
        cyc();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (bus.count !== 4'd0 || bus.out_valid_a !== 1'b0 || bus.out_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state count=%0d va=%0b vb=%0b required 0/0/0", bus.count, bus.out_valid_a, bus.out_valid_b);
        end
        n_tests++;
        if (bus.out_inst_a !== 32'd0 || bus.out_pc_a !== 32'd0 || bus.out_inst_b !== 32'd0 || bus.out_pc_b !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h %h %h %h required zeros", bus.out_inst_a, bus.out_pc_a, bus.out_inst_b, bus.out_pc_b);
        end
        n_tests++;
        if (bus.fq_ready !== 1'b1 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags ready=%0b ovf=%0b required 1/0", bus.fq_ready, bus.overflow);
        end
    endtask

    task automatic test_basic_pair();
        do_reset();
        drive(1'b1, 32'h00000013, 32'd0, 32'h00100093, 32'd4, 2'd0, 1'b0);
        cyc();
        idle();
        n_tests++;
        if (bus.count !== 4'd2 || bus.fq_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_count count=%0d ready=%0b required 2/1", bus.count, bus.fq_ready);
        end
        n_tests++;
        if (bus.out_valid_a !== 1'b1 || bus.out_inst_a !== 32'h13 || bus.out_pc_a !== 32'd0) begin
            n_fail++;
            $display("FAIL basic_slot_a v=%0b inst=%h pc=%h required 1/00000013/0", bus.out_valid_a, bus.out_inst_a, bus.out_pc_a);
        end
        n_tests++;
        if (bus.out_valid_b !== 1'b1 || bus.out_inst_b !== 32'h00100093 || bus.out_pc_b !== 32'd4) begin
            n_fail++;
            $display("FAIL basic_slot_b v=%0b inst=%h pc=%h required 1/00100093/4", bus.out_valid_b, bus.out_inst_b, bus.out_pc_b);
        end
    endtask

    // Continues from the basic pair (count=2).
    task automatic test_zero_lanes();
        drive(1'b1, 32'd0, 32'd8, 32'h00208133, 32'd12, 2'd0, 1'b0);
        cyc();
        idle();
        n_tests++;
        if (bus.count !== 4'd3) begin
            n_fail++;
            $display("FAIL zero_lane_a_count count=%0d required 3", bus.count);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd2, 1'b0);
        cyc();
        idle();
        n_tests++;
        if (bus.count !== 4'd1 || bus.out_inst_a !== 32'h00208133 || bus.out_pc_a !== 32'd12 || bus.out_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL compacted_entry count=%0d inst=%h pc=%0d vb=%0b required 1/00208133/12/0",
                     bus.count, bus.out_inst_a, bus.out_pc_a, bus.out_valid_b);
        end
        drive(1'b1, 32'd0, 32'd16, 32'd0, 32'd20, 2'd0, 1'b0);
        cyc();
        idle();
        n_tests++;
        if (bus.count !== 4'd1) begin
            n_fail++;
            $display("FAIL both_zero count=%0d required 1", bus.count);
        end
        // dec_take larger than occupancy is clamped.
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd2, 1'b0);
        cyc();
        idle();
        n_tests++;
        if (bus.count !== 4'd0 || bus.out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_clamp count=%0d va=%0b required 0/0", bus.count, bus.out_valid_a);
        end
    endtask

    task automatic test_fill_overflow();
        logic [3:0] exp_cnt [4];
        logic       exp_rdy [4];
        exp_cnt = '{4'd2, 4'd4, 4'd6, 4'd8};
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_pair(k, 2'd0);
            n_tests++;
            if (bus.count !== exp_cnt[k] || bus.fq_ready !== exp_rdy[k] || bus.overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_%0d count=%0d ready=%0b ovf=%0b required %0d/%0b/0",
                         k, bus.count, bus.fq_ready, bus.overflow, exp_cnt[k], exp_rdy[k]);
            end
        end
        push_pair(4, 2'd0);
        n_tests++;
        if (bus.count !== 4'd8 || bus.overflow !== 1'b1 || bus.out_pc_a !== 32'd0) begin
            n_fail++;
            $display("FAIL overflow_drop count=%0d ovf=%0b pc_a=%0d required 8/1/0", bus.count, bus.overflow, bus.out_pc_a);
        end
        cyc();
        n_tests++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky ovf=%0b required 1", bus.overflow);
        end
    endtask

    task automatic test_full_swap();
        do_reset();
        for (int k = 0; k < 4; k++) push_pair(k, 2'd0);
        push_pair(4, 2'd2);
        n_tests++;
        if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_swap count=%0d ovf=%0b required 8/0", bus.count, bus.overflow);
        end
        n_tests++;
        if (bus.out_pc_a !== 32'd8 || bus.out_pc_b !== 32'd12 || bus.out_inst_a !== 32'h1008) begin
            n_fail++;
            $display("FAIL full_swap_head pc_a=%0d pc_b=%0d inst_a=%h required 8/12/00001008",
                     bus.out_pc_a, bus.out_pc_b, bus.out_inst_a);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        push_pair(0, 2'd0);
        push_pair(1, 2'd0);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (bus.out_pc_a !== 32'(8*i) || bus.out_pc_b !== 32'(8*i+4)) begin
                n_fail++;
                $display("FAIL wrap_order_%0d pc_a=%0d pc_b=%0d required %0d/%0d", i, bus.out_pc_a, bus.out_pc_b, 8*i, 8*i+4);
            end
            push_pair(i + 2, 2'd2);
            n_tests++;
            if (bus.count !== 4'd4) begin
                n_fail++;
                $display("FAIL wrap_count_%0d count=%0d required 4", i, bus.count);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        push_pair(0, 2'd0);
        push_pair(1, 2'd0);
        drive(1'b1, 32'd0, 32'd16, 32'h1014, 32'd20, 2'd0, 1'b0);
        cyc();
        idle();
        n_tests++;
        if (bus.count !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_setup count=%0d required 5", bus.count);
        end
        drive(1'b1, 32'h2000, 32'h100, 32'h2004, 32'h104, 2'd1, 1'b1);
        cyc();
        idle();
        n_tests++;
        if (bus.count !== 4'd0 || bus.out_valid_a !== 1'b0 || bus.out_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear count=%0d va=%0b vb=%0b required 0/0/0", bus.count, bus.out_valid_a, bus.out_valid_b);
        end
        drive(1'b1, 32'h3000, 32'h200, 32'h3004, 32'h204, 2'd0, 1'b0);
        cyc();
        idle();
        n_tests++;
        if (bus.count !== 4'd0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop_next count=%0d ovf=%0b required 0/0", bus.count, bus.overflow);
        end
        drive(1'b1, 32'h4000, 32'h300, 32'h4004, 32'h304, 2'd0, 1'b0);
        cyc();
        idle();
        n_tests++;
        if (bus.count !== 4'd2 || bus.out_pc_a !== 32'h300 || bus.out_inst_b !== 32'h4004) begin
            n_fail++;
            $display("FAIL flush_resume count=%0d pc_a=%h inst_b=%h required 2/00000300/00004004",
                     bus.count, bus.out_pc_a, bus.out_inst_b);
        end
    endtask

    // Reset wins over a same-cycle flush: no stale-drop survives it.
    task automatic test_reset_mid();
        do_reset();
        push_pair(0, 2'd0);
        push_pair(1, 2'd0);
        push_pair(2, 2'd0);
        drive(1'b1, 32'h5000, 32'h400, 32'd0, 32'h404, 2'd0, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle();
        n_tests++;
        if (bus.count !== 4'd0 || bus.out_valid_a !== 1'b0 || bus.out_pc_a !== 32'd0 ||
            bus.fq_ready !== 1'b1 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid count=%0d va=%0b pc_a=%h ready=%0b ovf=%0b required 0/0/0/1/0",
                     bus.count, bus.out_valid_a, bus.out_pc_a, bus.fq_ready, bus.overflow);
        end
        push_pair(7, 2'd0);
        n_tests++;
        if (bus.count !== 4'd2 || bus.out_pc_a !== 32'd56) begin
            n_fail++;
            $display("FAIL reset_clears_drop count=%0d pc_a=%0d required 2/56", bus.count, bus.out_pc_a);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        idle();
        test_reset();
        test_basic_pair();
        test_zero_lanes();
        test_fill_overflow();
        test_full_swap();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
